// File: rtl/vtg_pkg.sv
// ============================================================================
// Module : vtg_pkg
// Brief  : Shared types and helpers for the video timing / IRQ block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vtg_pkg;

  localparam int IRQ_IDX_W     = 3;
  localparam int DEFAULT_CNT_W = 9;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  // Modulo addition for operands that are each already below total
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned total);
    int unsigned sum;
    sum = a + b;
    return (sum >= total) ? sum - total : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vtg_sync_window.sv
// ============================================================================
// Module : vtg_sync_window
// Brief  : Wrap-aware [start, start+WIDTH) window flag on a modulo-TOTAL counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vtg_sync_window #(
  parameter int CNT_W = 9,
  parameter int TOTAL = 320,
  parameter int WIDTH = 32
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W:0]   start,
  output logic             in_window
);

  localparam logic [CNT_W:0] TOTAL_X = (CNT_W+1)'(TOTAL);
  localparam logic [CNT_W:0] WIDTH_X = (CNT_W+1)'(WIDTH);

  logic [CNT_W:0] cnt_x;
  logic [CNT_W:0] offset;

  assign cnt_x = {1'b0, cnt};

  // Forward distance from start, measured across the counter wrap
  assign offset    = (cnt_x >= start) ? (cnt_x - start) : (cnt_x + TOTAL_X - start);
  assign in_window = (offset < WIDTH_X);

endmodule

`default_nettype wire

// File: rtl/video_timing_irq.sv
// ============================================================================
// Module : video_timing_irq
// Brief  : Raster H/V timing with centred sync and a prioritised multi-source
//          IRQ controller. Macro VIDEO_TIMING_IRQ_FRAME_CNT_EN enables frame_cnt.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_irq
  import vtg_pkg::*;
#(
  parameter int CNT_W          = 9,
  parameter int H_TOTAL        = 320,
  parameter int H_ACTIVE       = 256,
  parameter int H_SYNC_START   = 280,
  parameter int H_SYNC_WIDTH   = 32,
  parameter int V_TOTAL        = 264,
  parameter int V_ACTIVE_START = 16,
  parameter int V_ACTIVE_END   = 240,
  parameter int V_SYNC_START   = 248,
  parameter int V_SYNC_WIDTH   = 4,
  parameter int NUM_LINE_IRQ   = 2
) (
  input  logic                          clk_49m,
  input  logic                          reset,
  input  logic                          ce_pix,
  input  logic [3:0]                    h_center,
  input  logic [3:0]                    v_center,
  input  logic [NUM_LINE_IRQ*CNT_W-1:0] irq_line,
  input  logic [NUM_LINE_IRQ:0]         irq_en,
  input  logic                          irq_ack,
  output logic [CNT_W-1:0]              h_cnt,
  output logic [CNT_W-1:0]              v_cnt,
  output logic                          hblank,
  output logic                          vblank,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          csync,
  output logic                          n_irq,
  output logic [NUM_LINE_IRQ:0]         irq_pending,
  output logic [IRQ_IDX_W-1:0]          irq_vector,
  output logic [7:0]                    frame_cnt
);

  localparam int NSRC = NUM_LINE_IRQ + 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_ACTIVE_START);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_ACTIVE_END);

  logic             h_wrap;
  logic [CNT_W-1:0] v_next;
  logic [CNT_W:0]   hs_start;
  logic [CNT_W:0]   vs_start;

  assign h_wrap = ce_pix && (h_cnt == H_LAST);
  assign v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce_pix) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= v_next;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hblank = (h_cnt >= H_ACT);
  assign vblank = (v_cnt < V_ACT_S) || (v_cnt >= V_ACT_E);

  assign hs_start = (CNT_W+1)'(wrap_add(H_SYNC_START, 32'(h_center), H_TOTAL));
  assign vs_start = (CNT_W+1)'(wrap_add(V_SYNC_START, 32'(v_center), V_TOTAL));

  vtg_sync_window #(
    .CNT_W (CNT_W),
    .TOTAL (H_TOTAL),
    .WIDTH (H_SYNC_WIDTH)
  ) u_hsync_win (
    .cnt       (h_cnt),
    .start     (hs_start),
    .in_window (hsync)
  );

  vtg_sync_window #(
    .CNT_W (CNT_W),
    .TOTAL (V_TOTAL),
    .WIDTH (V_SYNC_WIDTH)
  ) u_vsync_win (
    .cnt       (v_cnt),
    .start     (vs_start),
    .in_window (vsync)
  );

  assign csync = ~(hsync ^ vsync);

  logic [NUM_LINE_IRQ:0]  irq_set;
  logic [NUM_LINE_IRQ:0]  irq_clr;
  logic [NUM_LINE_IRQ:0]  irq_active;
  logic [IRQ_IDX_W-1:0]   winner;
  logic                   ack_d;

  genvar k;
  generate
    for (k = 0; k < NUM_LINE_IRQ; k++) begin : g_line_set
      assign irq_set[k] = h_wrap && (v_next == irq_line[k*CNT_W +: CNT_W]);
    end
  endgenerate

  assign irq_set[NUM_LINE_IRQ] = h_wrap && (v_next == V_ACT_E);
  assign irq_active            = irq_pending & irq_en;

  // VBlank outranks every line source; among lines the lowest index wins
  always_comb begin
    winner = '0;
    for (int i = NUM_LINE_IRQ - 1; i >= 0; i--) begin
      if (irq_active[i]) winner = IRQ_IDX_W'(i);
    end
    if (irq_active[NUM_LINE_IRQ]) winner = IRQ_IDX_W'(NUM_LINE_IRQ);
  end

  // Only a fresh ack edge while an IRQ is being signalled clears the winner
  always_comb begin
    irq_clr = '0;
    if (irq_ack && !ack_d && !n_irq) begin
      for (int i = 0; i < NSRC; i++) begin
        if (irq_vector == IRQ_IDX_W'(i)) irq_clr[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      irq_pending <= '0;
      n_irq       <= 1'b1;
      irq_vector  <= '0;
      ack_d       <= 1'b0;
    end else begin
      irq_pending <= (irq_pending & ~irq_clr) | irq_set;
      n_irq       <= ~|irq_active;
      irq_vector  <= winner;
      ack_d       <= irq_ack;
    end
  end

`ifdef VIDEO_TIMING_IRQ_FRAME_CNT_EN
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (h_wrap && (v_cnt == V_LAST)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_timing_irq.sv
// ============================================================================
// Module : tb_video_timing_irq
// Brief  : Self-checking bench for video_timing_irq at default parameters.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_video_timing_irq;

  localparam int HT    = 320;
  localparam int VT    = 264;
  localparam int FRAME = HT * VT;

  logic        clk_49m = 1'b0;
  logic        reset   = 1'b1;
  logic        ce_pix  = 1'b0;
  logic [3:0]  h_center = 4'd0;
  logic [3:0]  v_center = 4'd0;
  logic [17:0] irq_line = {9'd100, 9'd50};
  logic [2:0]  irq_en   = 3'b111;
  logic        irq_ack  = 1'b0;

  logic [8:0]  h_cnt;
  logic [8:0]  v_cnt;
  logic        hblank, vblank, hsync, vsync, csync, n_irq;
  logic [2:0]  irq_pending;
  logic [2:0]  irq_vector;
  logic [7:0]  frame_cnt;

  video_timing_irq dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .h_center    (h_center),
    .v_center    (v_center),
    .irq_line    (irq_line),
    .irq_en      (irq_en),
    .irq_ack     (irq_ack),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync       (hsync),
    .vsync       (vsync),
    .csync       (csync),
    .n_irq       (n_irq),
    .irq_pending (irq_pending),
    .irq_vector  (irq_vector),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_49m = ~clk_49m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raster position as a single pixel index in the frame
  int         m_pix;
  logic [2:0] m_pend;
  logic       m_nirq;
  int         m_vec;
  logic       m_ack_q;
  int         m_frame;

  function automatic int pmod(input int a, input int m);
    return ((a % m) + m) % m;
  endfunction

  function automatic logic in_win(input int c, input int nominal, input int ctr,
                                  input int total, input int width);
    int s;
    s = (nominal + ctr) % total;
    return pmod(c - s, total) < width;
  endfunction

  task automatic model_reset();
    m_pix = 0; m_pend = 3'b000; m_nirq = 1'b1; m_vec = 0; m_ack_q = 1'b0; m_frame = 0;
  endtask

  task automatic model_edge();
    int h, v, nv, nvec;
    logic [2:0] act, clr, set;
    h = m_pix % HT;
    v = m_pix / HT;
    act  = m_pend & irq_en;
    nvec = act[2] ? 2 : act[0] ? 0 : act[1] ? 1 : 0;
    clr  = 3'b000;
    if (irq_ack && !m_ack_q && !m_nirq) clr[m_vec] = 1'b1;
    set = 3'b000;
    if (ce_pix && h == HT - 1) begin
      nv = (v + 1) % VT;
      set[0] = (nv == int'(irq_line[8:0]));
      set[1] = (nv == int'(irq_line[17:9]));
      set[2] = (nv == 240);
    end
    m_pend = (m_pend & ~clr) | set;
    if (ce_pix) begin
`ifdef VIDEO_TIMING_IRQ_FRAME_CNT_EN
      if (m_pix == FRAME - 1) m_frame = (m_frame + 1) % 256;
`endif
      m_pix = (m_pix + 1) % FRAME;
    end
    m_nirq  = (act == 3'b000);
    m_vec   = nvec;
    m_ack_q = irq_ack;
  endtask

  task automatic check_all();
    int h, v;
    logic hs, vs;
    h  = m_pix % HT;
    v  = m_pix / HT;
    hs = in_win(h, 280, int'(h_center), HT, 32);
    vs = in_win(v, 248, int'(v_center), VT, 4);
    chk("h_cnt", h_cnt, h);
    chk("v_cnt", v_cnt, v);
    chk("hblank", hblank, h >= 256);
    chk("vblank", vblank, (v < 16) || (v >= 240));
    chk("hsync", hsync, hs);
    chk("vsync", vsync, vs);
    chk("csync", csync, !(hs ^ vs));
    chk("n_irq", n_irq, m_nirq);
    chk("irq_pending", irq_pending, m_pend);
    chk("irq_vector", irq_vector, m_vec);
    chk("frame_cnt", frame_cnt, m_frame);
  endtask

  task automatic step();
    @(posedge clk_49m);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to(input int h, input int v);
    int target, n;
    target = v * HT + h;
    n = 0;
    while (m_pix != target) begin
      if (n >= 100000) begin
        checks++;
        errors++;
        $display("FAIL run_to_timeout actual_pix=%0d required_pix=%0d", m_pix, target);
        return;
      end
      ce_pix = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 511) == 0) begin
        h_center = 4'($urandom);
        v_center = 4'($urandom);
      end
      step();
      n++;
    end
  endtask

  typedef struct {
    int         h;
    int         v;
    logic [3:0] hc;
    logic [3:0] vc;
    logic       hb, vb, hs, vs, cs;
  } vrec_t;

  vrec_t tbl[$];

  task automatic add(input int h, input int v, input int hc, input int vc,
                     input logic hb, input logic vb, input logic hs,
                     input logic vs, input logic cs);
    tbl.push_back('{h, v, 4'(hc), 4'(vc), hb, vb, hs, vs, cs});
  endtask

  task automatic apply_vec(input int i);
    run_to(tbl[i].h, tbl[i].v);
    h_center = tbl[i].hc;
    v_center = tbl[i].vc;
    #1;
    chk($sformatf("vec%0d_hblank", i), hblank, tbl[i].hb);
    chk($sformatf("vec%0d_vblank", i), vblank, tbl[i].vb);
    chk($sformatf("vec%0d_hsync", i), hsync, tbl[i].hs);
    chk($sformatf("vec%0d_vsync", i), vsync, tbl[i].vs);
    chk($sformatf("vec%0d_csync", i), csync, tbl[i].cs);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //     h    v   hc  vc  hb    vb    hs    vs    cs
    add(  0,   3,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(255,   3,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(256,   3,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(279,   4,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(280,   4,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(311,   4,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(312,   4,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(294,   5, 15,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(295,   5, 15,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(319,   5, 15,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(  0,   6, 15,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(  6,   6, 15,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(  7,   6, 15,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add( 10,  15,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add( 10,  16,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(100, 239,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(100, 247,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(100, 248,  0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(100, 251,  0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(100, 252,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(100, 252,  0,  4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(290, 252,  0,  4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add(100, 263,  0, 15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(100,   0,  0, 15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Power-on reset values
    #3 reset = 1'b0;
    #4;
    model_reset();
    check_all();
    #20 reset = 1'b1;

    // Mid-line asynchronous reset
    run_to(123, 2);
    #2 reset = 1'b0;
    #1;
    chk("rst_h_cnt", h_cnt, 0);
    chk("rst_v_cnt", v_cnt, 0);
    chk("rst_pending", irq_pending, 0);
    chk("rst_n_irq", n_irq, 1);
    chk("rst_vector", irq_vector, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_vblank", vblank, 1);
    model_reset();
    repeat (2) @(posedge clk_49m);
    #3 reset = 1'b1;

    for (int i = 0; i < 15; i++) apply_vec(i);

    // Line 50 on source 0
    run_to(0, 50);
    chk("l50_pending", irq_pending, 3'b001);
    chk("l50_n_irq_reg", n_irq, 1);
    ce_pix = 1'b0;
    step();
    chk("l50_n_irq", n_irq, 0);
    chk("l50_vector", irq_vector, 0);
    irq_ack = 1'b1;
    step();
    chk("l50_ack_pending", irq_pending, 3'b000);
    step();
    chk("l50_ack_n_irq", n_irq, 1);
    irq_ack = 1'b0;
    step();

    // Line 100 on source 1, then set and ack of the same source on one edge
    run_to(0, 100);
    chk("l100_pending", irq_pending, 3'b010);
    ce_pix = 1'b0;
    step();
    chk("l100_vector", irq_vector, 1);
    chk("l100_n_irq", n_irq, 0);
    irq_line[17:9] = 9'd101;
    run_to(319, 100);
    ce_pix  = 1'b1;
    irq_ack = 1'b1;
    step();
    chk("setwins_pending", irq_pending, 3'b010);
    chk("setwins_v_cnt", v_cnt, 101);
    irq_ack = 1'b0;
    ce_pix  = 1'b0;
    step();
    irq_ack = 1'b1;
    step();
    chk("l101_ack_pending", irq_pending, 3'b000);
    irq_ack = 1'b0;
    step();
    chk("l101_n_irq", n_irq, 1);

    // Line 240: source 0 and VBlank together, VBlank initially disabled
    irq_line[8:0] = 9'd240;
    irq_en = 3'b010;
    for (int i = 15; i < 16; i++) apply_vec(i);
    run_to(0, 240);
    chk("l240_pending", irq_pending, 3'b101);
    ce_pix = 1'b0;
    step();
    chk("l240_disabled_n_irq", n_irq, 1);
    chk("l240_disabled_pending", irq_pending, 3'b101);
    irq_en = 3'b111;
    step();
    chk("l240_reenable_n_irq", n_irq, 0);
    chk("l240_vector", irq_vector, 2);
    irq_ack = 1'b1;
    repeat (5) step();
    chk("hold_ack_pending", irq_pending, 3'b001);
    chk("hold_ack_vector", irq_vector, 0);
    chk("hold_ack_n_irq", n_irq, 0);
    irq_ack = 1'b0;
    step();
    irq_ack = 1'b1;
    step();
    chk("second_ack_pending", irq_pending, 3'b000);
    irq_ack = 1'b0;
    step();
    chk("second_ack_n_irq", n_irq, 1);
    chk("second_ack_vector", irq_vector, 0);

    for (int i = 16; i < tbl.size(); i++) apply_vec(i);

`ifdef VIDEO_TIMING_IRQ_FRAME_CNT_EN
    chk("frame_cnt_after_frame", frame_cnt, 1);
`else
    chk("frame_cnt_after_frame", frame_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
